velocity_bcd_encoder: RTL and testbench
=======================================

// Module: velocity_bcd_encoder
// PURPOSE
//  Consumer end of the car-velocity interface. Takes a signed fixed-point car velocity and turns it into three decimal digits.
//  The digits are hundred/ten/one, with leading-zero blank flags, for the HUD speed readout.
//  It sits between the car physics update and the bar-digit renderer, which draws HUNDRED/TEN/ONE/BG tiles.
//  Runs one conversion per request, typically one per frame, using an iterative double-dabble.
// PARAMETERS
//  VEL_INT_W   4   integer bits of input velocity (2's complement, MSB weight -2^(VEL_INT_W-1))
//  VEL_FRAC_W  6   fraction bits of input velocity
//  DROP_W      3   LSBs discarded from magnitude before display
//  OUT_W       7   display magnitude width (= VEL_INT_W+VEL_FRAC_W-DROP_W); saturates to 2^OUT_W-1; must be <=9
// PORTS
//  i_clk        in   1                     system clock
//  i_rst        in   1                     synchronous, active-high reset
//  i_start      in   1                     request conversion; sampled only in IDLE
//  i_velocity   in   VEL_INT_W+VEL_FRAC_W  signed fixed-point velocity
//  o_busy       out  1                     high while not IDLE
//  o_valid      out  1                     one-cycle pulse: new digits on outputs
//  o_hundred    out  4                     BCD hundreds digit
//  o_ten        out  4                     BCD tens digit
//  o_one        out  4                     BCD ones digit
//  o_blank_hun  out  1                     hundreds digit is a leading zero (renderer draws BG)
//  o_blank_ten  out  1                     hundreds and tens both zero
//  o_negative   out  1                     input negative AND display magnitude nonzero
// BEHAVIOUR
//  Reset: state=IDLE; o_busy=0; o_valid=0; digits=0; o_blank_hun=1; o_blank_ten=1; o_negative=0.
//   Reset wins over everything, including mid-conversion; no partial result is ever published.
//  Input capture, on the edge where IDLE && i_start:
//   - mag = |i_velocity| computed in VEL_INT_W+VEL_FRAC_W+1 bits, so the most-negative input is exact.
//   - shifted = mag >> DROP_W, truncated toward zero.
//   - disp = min(shifted, 2^OUT_W-1).
//   - Latch disp into the shift register and neg = sign bit; clear BCD accumulator; cnt=0; go to CONV.
//  FSM states: IDLE -> CONV -> DONE -> IDLE.
//   CONV: one double-dabble step per cycle, OUT_W cycles total.
//    Each step: every BCD nibble >=5 gets +3, then {bcd,sr} shifts left by 1.
//    cnt increments each step; after step OUT_W-1 go to DONE.
//   DONE: on the next edge, register the BCD nibbles to o_hundred/o_ten/o_one.
//    Same edge: o_blank_hun = (hun==0); o_blank_ten = (hun==0 && ten==0); o_negative = neg && (disp!=0).
//    Same edge: o_valid=1 for exactly one cycle; go to IDLE.
//  Latency: start sampled at edge N -> o_valid high in the cycle after edge N+OUT_W+1.
//   With defaults that is 9 cycles, so o_busy is high for OUT_W+1 cycles.
//  Output hold: the ones digit is never blanked. Output digits and flags hold their value between o_valid pulses.
//  i_start while busy is ignored, not queued. i_velocity is only sampled at capture, so it may change freely during CONV.
//  i_start high in the same cycle as o_valid: accepted only if already IDLE. Not accepted in DONE; the next IDLE cycle accepts it.
//  Width rule: BCD accumulator is 12 bits, enough for 511 when OUT_W<=9. No nibble exceeds 9 at output.
// TESTING
//  1) i_velocity=10'h000, start -> after 9 cycles o_valid; digits 0/0/0, blank_hun=1, blank_ten=1, negative=0.
//  2) i_velocity=10'h1C0 (+7.0) -> disp 56: 0/5/6, blank_hun=1, blank_ten=0, negative=0.
//  3) i_velocity=10'h200 (-8.0) -> disp 64: 0/6/4, negative=1. Also 10'h3FF (-1/64) -> 0/0/0, negative=0.
//  4) Override OUT_W=5, i_velocity=10'h1C0 -> saturates to 31: 0/3/1, o_valid after OUT_W+2=7 cycles.
//  5) Start 10'h1C0, then pulse i_start with 10'h040 at cycle 3 -> single o_valid with 0/5/6; second start has no effect.
//  6) Assert i_rst at cycle 4 of CONV -> next cycle all outputs at reset values. No o_valid follows; a fresh start converts correctly.

Source files
------------

// File: rtl/velocity_bcd_encoder.sv
// velocity_bcd_encoder: signed fixed-point velocity to three BCD digits via iterative double-dabble
module velocity_bcd_encoder #(
  parameter int VEL_INT_W  = 4,
  parameter int VEL_FRAC_W = 6,
  parameter int DROP_W     = 3,
  parameter int OUT_W      = 7
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic [VEL_INT_W+VEL_FRAC_W-1:0] i_velocity,
  output logic                            o_busy,
  output logic                            o_valid,
  output logic [3:0]                      o_hundred,
  output logic [3:0]                      o_ten,
  output logic [3:0]                      o_one,
  output logic                            o_blank_hun,
  output logic                            o_blank_ten,
  output logic                            o_negative
);
  localparam int W  = VEL_INT_W + VEL_FRAC_W;
  localparam int SW = W + 1 - DROP_W;
  localparam logic [SW-1:0] DISP_MAX = SW'((1 << OUT_W) - 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_n;
  logic [W:0] ext, mag;
  logic [SW-1:0] shifted;
  logic [OUT_W-1:0] disp, sr;
  logic [11:0] bcd, bcd_adj;
  logic [11+OUT_W:0] step;
  logic [3:0] cnt;
  logic neg, nz;
  // magnitude, drop, saturate, and the add-3 correction for the next shift
  always_comb begin
    ext     = {i_velocity[W-1], i_velocity};
    mag     = i_velocity[W-1] ? ~ext + 1'b1 : ext;
    shifted = SW'(mag >> DROP_W);
    disp    = shifted > DISP_MAX ? '1 : shifted[OUT_W-1:0];
    bcd_adj[11:8] = bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8];
    bcd_adj[7:4]  = bcd[7:4]  >= 4'd5 ? bcd[7:4]  + 4'd3 : bcd[7:4];
    bcd_adj[3:0]  = bcd[3:0]  >= 4'd5 ? bcd[3:0]  + 4'd3 : bcd[3:0];
    step    = {bcd_adj, sr} << 1;
  end
  // next state: IDLE -> CONV for OUT_W steps -> DONE -> IDLE
  always_comb begin
    state_n = state == IDLE ? (i_start ? CONV : IDLE)
            : state == CONV ? (cnt == 4'(OUT_W - 1) ? DONE : CONV)
            : IDLE;
  end
  // state register, conversion datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      sr          <= '0;
      bcd         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      nz          <= 1'b0;
      o_valid     <= 1'b0;
      o_hundred   <= '0;
      o_ten       <= '0;
      o_one       <= '0;
      o_blank_hun <= 1'b1;
      o_blank_ten <= 1'b1;
      o_negative  <= 1'b0;
    end else begin
      state   <= state_n;
      o_valid <= 1'b0;
      if (state == IDLE && i_start) begin
        sr  <= disp;
        bcd <= '0;
        cnt <= '0;
        neg <= i_velocity[W-1];
        nz  <= disp != '0;
      end else if (state == CONV) begin
        {bcd, sr} <= step;
        cnt       <= cnt + 4'd1;
      end else if (state == DONE) begin
        o_hundred   <= bcd[11:8];
        o_ten       <= bcd[7:4];
        o_one       <= bcd[3:0];
        o_blank_hun <= bcd[11:8] == 4'd0;
        o_blank_ten <= bcd[11:4] == 8'd0;
        o_negative  <= neg && nz;
        o_valid     <= 1'b1;
      end
    end
  end
  assign o_busy = state != IDLE;
endmodule

// File: tb/tb_velocity_bcd_encoder.sv
// tb_velocity_bcd_encoder: randomized and directed checks against a latency/arithmetic model
module tb_velocity_bcd_encoder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, en = 1'b0;
  logic [9:0] vel = '0;
  logic busy[2], valid[2], bh[2], bt[2], ng[2];
  logic [3:0] hun[2], ten[2], one[2];
  int cmp = 0, bad = 0;
  int ow[2] = '{7, 5};
  int rem[2];
  logic [14:0] eo[2];
  logic ev[2];
  logic [9:0] vl[2];
  localparam logic [14:0] RST_OUT = {1'b0, 1'b1, 1'b1, 12'h000};

  always #5 clk = ~clk;

  velocity_bcd_encoder dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_velocity(vel),
    .o_busy(busy[0]), .o_valid(valid[0]), .o_hundred(hun[0]), .o_ten(ten[0]), .o_one(one[0]),
    .o_blank_hun(bh[0]), .o_blank_ten(bt[0]), .o_negative(ng[0]));

  velocity_bcd_encoder #(.OUT_W(5)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_velocity(vel),
    .o_busy(busy[1]), .o_valid(valid[1]), .o_hundred(hun[1]), .o_ten(ten[1]), .o_one(one[1]),
    .o_blank_hun(bh[1]), .o_blank_ten(bt[1]), .o_negative(ng[1]));

  // expected {negative, blank_hun, blank_ten, hundred, ten, one} from plain arithmetic
  function automatic logic [14:0] model(input logic [9:0] v, input int w);
    int s, m, d, h, t, o;
    s = $signed(v);
    m = s < 0 ? -s : s;
    d = m / 8;
    if (d > (1 << w) - 1) d = (1 << w) - 1;
    h = d / 100;
    t = (d / 10) % 10;
    o = d % 10;
    return {s < 0 && d != 0, h == 0, h == 0 && t == 0, 4'(h), 4'(t), 4'(o)};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // model: a request is accepted only when nothing is in flight; result appears OUT_W+1 edges later
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        rem[d] <= 0;
        eo[d]  <= RST_OUT;
        ev[d]  <= 1'b0;
      end else if (rem[d] == 0 && start) begin
        rem[d] <= ow[d] + 1;
        vl[d]  <= vel;
        ev[d]  <= 1'b0;
      end else if (rem[d] > 0) begin
        rem[d] <= rem[d] - 1;
        ev[d]  <= rem[d] == 1;
        if (rem[d] == 1) eo[d] <= model(vl[d], ow[d]);
      end else begin
        ev[d] <= 1'b0;
      end
    end
  end

  // compare every output of both instances on every cycle
  always @(negedge clk) begin
    if (en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(rem[d] > 0));
        chk($sformatf("d%0d_valid", d), 32'(valid[d]), 32'(ev[d]));
        chk($sformatf("d%0d_outs", d), 32'({ng[d], bh[d], bt[d], hun[d], ten[d], one[d]}), 32'(eo[d]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input logic [9:0] v);
    vel = v;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    logic [9:0] dir[6] = '{10'h000, 10'h1C0, 10'h200, 10'h3FF, 10'h1FF, 10'h040};
    cyc(3);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_outs", 32'({ng[0], bh[0], bt[0], hun[0], ten[0], one[0]}), 32'(RST_OUT));
    rst = 1'b0;
    en = 1'b1;
    chk("pin_1C0", 32'(model(10'h1C0, 7)), 32'({1'b0, 1'b1, 1'b0, 12'h056}));
    chk("pin_200", 32'(model(10'h200, 7)), 32'({1'b1, 1'b1, 1'b0, 12'h064}));
    chk("pin_3FF", 32'(model(10'h3FF, 7)), 32'({1'b0, 1'b1, 1'b1, 12'h000}));
    chk("pin_1FF", 32'(model(10'h1FF, 7)), 32'({1'b0, 1'b1, 1'b0, 12'h063}));
    chk("pin_sat5", 32'(model(10'h1C0, 5)), 32'({1'b0, 1'b1, 1'b0, 12'h031}));
    chk("pin_sat5n", 32'(model(10'h200, 5)), 32'({1'b1, 1'b1, 1'b0, 12'h031}));
    foreach (dir[i]) begin
      go(dir[i]);
      cyc(12);
    end
    go(10'h1C0);
    cyc(2);
    go(10'h040);
    cyc(12);
    chk("busy_start_ignored", 32'({hun[0], ten[0], one[0]}), 32'h056);
    vel = 10'($urandom);
    start = 1'b1;
    cyc(30);
    start = 1'b0;
    cyc(12);
    go(10'h1C0);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midconv_rst", 32'({busy[0], valid[0], ng[0], bh[0], bt[0], hun[0], ten[0], one[0]}), 32'({3'b000, RST_OUT}));
    cyc(12);
    go(10'h200);
    cyc(12);
    chk("after_rst", 32'({ng[0], hun[0], ten[0], one[0]}), 32'({1'b1, 12'h064}));
    repeat (800) begin
      vel = 10'($urandom);
      start = $urandom_range(0, 2) == 0;
      rst = $urandom_range(0, 60) == 0;
      cyc(1);
    end
    start = 1'b0;
    rst = 1'b0;
    cyc(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
